fmul_wb: RTL and testbench
==========================

FMUL_WB -- requirements
Module: fmul_wb

Interface
REQ-001 Parameter NSTAGE, default 3, is the fmul pipeline latency in cycles, measured from operands presented to y valid.
REQ-002 Parameter DEPTH, default 4, is the result FIFO depth and the maximum number of operations in flight plus buffered.
REQ-003 Parameter TAGW, default 6, is the destination tag width.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 flush  in  1  discards all in-flight and buffered results.
REQ-007 issue_valid  in  1  upstream presents x1/x2 to fmul this cycle.
REQ-008 issue_tag  in  TAGW  destination tag of the issued operation.
REQ-009 issue_ready  out  1  an issue is accepted this cycle.
REQ-010 mul_y  in  32  fmul y output.
REQ-011 mul_ovf  in  1  fmul ovf output; it is valid one cycle before the matching y.
REQ-012 wb_valid  out  1  FIFO head valid.
REQ-013 wb_ready  in  1  consumer accepts the head.
REQ-014 wb_data  out  32  head result.
REQ-015 wb_tag  out  TAGW  head tag.
REQ-016 wb_ovf  out  1  head overflow flag.
REQ-017 err  out  1  sticky flag: issue attempted while not ready.

Function
REQ-018 Accepted issue: issue_valid && issue_ready && !flush.
REQ-019 A tag/valid shift pipeline SHALL have NSTAGE slots; an issue accepted in cycle t occupies slot k in cycle t+k.
REQ-020 mul_ovf SHALL be sampled in the cycle where a valid op is in slot NSTAGE-1, and carried with that op into slot NSTAGE.
REQ-021 mul_y SHALL be sampled in the cycle where a valid op is in slot NSTAGE, and pushed into the FIFO with its tag and carried ovf.
REQ-022 Issue-to-wb_valid latency SHALL be exactly NSTAGE+1 cycles when the FIFO is empty; there is no bypass path.
REQ-023 FIFO SHALL be a DEPTH-entry circular buffer with wrapping read and write pointers and a count register of width clog2(DEPTH)+1.
REQ-024 Pop: wb_valid && wb_ready; the head advances at the clock edge.
REQ-025 A simultaneous push and pop SHALL leave the count unchanged; a push into a full FIFO cannot occur (guaranteed by REQ-026).
REQ-026 inflight SHALL count the valid pipeline slots; issue_ready = (inflight + count < DEPTH).
REQ-027 issue_ready SHALL NOT consider a same-cycle pop (conservative credit).
REQ-028 issue_valid && !issue_ready SHALL drop the op, leave state unchanged, and set err.
REQ-029 wb_data, wb_tag and wb_ovf SHALL be 0 whenever wb_valid = 0.
REQ-030 flush SHALL clear all pipeline valids, the FIFO pointers and the count at the next edge; any same-cycle issue or pop is ignored.
REQ-031 err is cleared only by rst.

Reset
REQ-032 rst has priority over flush.
REQ-033 While rst is high, at the next edge all valids, pointers, counts and err SHALL be set to 0.
REQ-034 After reset: issue_ready = 1, wb_valid = 0, wb_data = 0, wb_tag = 0, wb_ovf = 0, err = 0.
REQ-035 An rst asserted with operations in flight SHALL drop those operations; no wb_valid may result from them.

Verification
REQ-036 Single op: tag 5 issued at cycle 0, mul_ovf = 1 at cycle 2, mul_y = 0x40400000 at cycle 3 -> wb_valid at cycle 4 with wb_data 0x40400000, wb_tag 5, wb_ovf 1.
REQ-037 Back-pressure: wb_ready = 0, issue every cycle -> exactly 4 accepted, issue_ready = 0 from cycle 4, FIFO full, err stays 0 if issue_valid follows issue_ready.
REQ-038 Over-issue: issue_valid = 1 while issue_ready = 0 -> op dropped, err = 1 and held, later results unaffected.
REQ-039 Streaming: wb_ready = 1 with 20 back-to-back issues using tags 0..19 -> results emerge in order, tags match, pointers wrap without loss.
REQ-040 Flush: flush with 2 ops in flight and 2 buffered -> next cycle wb_valid = 0, issue_ready = 1, and no stale results appear later.
REQ-041 Reset mid-stream: rst asserted in the cycle a push occurs -> all outputs return to their reset values and the push is discarded.

Source files
------------

// File: rtl/fmul_wb.sv
// Writeback stage for a fixed-latency fmul: tracks issued tags through a shift
// pipeline, captures ovf/y at their slots, and buffers results in a credit-checked FIFO.
module fmul_wb #(
    parameter int NSTAGE = 3,
    parameter int DEPTH  = 4,
    parameter int TAGW   = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            issue_valid,
    input  logic [TAGW-1:0] issue_tag,
    output logic            issue_ready,
    input  logic [31:0]     mul_y,
    input  logic            mul_ovf,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [31:0]     wb_data,
    output logic [TAGW-1:0] wb_tag,
    output logic            wb_ovf,
    output logic            err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    // r_vld[k-1] / r_tag[k-1] hold pipeline slot k
    logic [NSTAGE-1:0] r_vld;
    logic [TAGW-1:0]   r_tag [NSTAGE];
    logic              r_ovf;
    logic [31:0]       r_mem_data [DEPTH];
    logic [TAGW-1:0]   r_mem_tag  [DEPTH];
    logic              r_mem_ovf  [DEPTH];
    logic [PW-1:0]     r_wr;
    logic [PW-1:0]     r_rd;
    logic [CW-1:0]     r_cnt;
    logic              r_err;

    logic              w_acc;
    logic [NSTAGE:0]   w_slots;
    logic              w_push;
    logic              w_pop;
    logic [31:0]       w_infl;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == PW'(DEPTH - 1)) ? PW'(0) : p + PW'(1);
    endfunction

    assign w_acc    = issue_valid && issue_ready && !flush;
    assign w_slots  = {r_vld, w_acc};
    assign w_push   = r_vld[NSTAGE-1];
    assign wb_valid = (r_cnt != CW'(0));
    assign w_pop    = wb_valid && wb_ready;
    assign err      = r_err;

    // Count occupied pipeline slots for the issue credit check
    always_comb begin
        w_infl = 32'd0;
        for (int k = 0; k < NSTAGE; k++) begin
            w_infl = w_infl + {31'd0, r_vld[k]};
        end
    end

    // Credit excludes a same-cycle pop on purpose
    assign issue_ready = (w_infl + 32'(r_cnt)) < 32'(DEPTH);

    assign wb_data = wb_valid ? r_mem_data[r_rd] : 32'd0;
    assign wb_tag  = wb_valid ? r_mem_tag[r_rd]  : {TAGW{1'b0}};
    assign wb_ovf  = wb_valid ? r_mem_ovf[r_rd]  : 1'b0;

    // Slot valid shift register, cleared by reset or flush
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_vld <= '0;
        end else begin
            for (int k = NSTAGE - 1; k > 0; k--) begin
                r_vld[k] <= r_vld[k-1];
            end
            r_vld[0] <= w_acc;
        end
    end

    // Tag shift and ovf capture; ovf is valid one cycle ahead of y
    always_ff @(posedge clk) begin
        for (int k = NSTAGE - 1; k > 0; k--) begin
            r_tag[k] <= r_tag[k-1];
        end
        r_tag[0] <= issue_tag;
        r_ovf    <= w_slots[NSTAGE-1] ? mul_ovf : 1'b0;
    end

    // Result storage write port
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr] <= mul_y;
            r_mem_tag[r_wr]  <= r_tag[NSTAGE-1];
            r_mem_ovf[r_wr]  <= r_ovf;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= ptr_inc(r_wr);
            if (w_pop)  r_rd <= ptr_inc(r_rd);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Sticky over-issue flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (issue_valid && !issue_ready) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

endmodule

// File: tb/tb_fmul_wb.sv
// Bench for fmul_wb: acts as the fmul (drives ovf/y at the right cycles, noise
// elsewhere) and checks every cycle against an in-order scoreboard.
module tb_fmul_wb;

    localparam int NSTAGE = 3;
    localparam int DEPTH  = 4;
    localparam int TAGW   = 6;

    typedef struct packed {
        logic [TAGW-1:0] tag;
        logic [31:0]     y;
        logic            ovf;
    } op_t;

    logic clk = 1'b0;
    logic rst, flush, issue_valid, issue_ready, mul_ovf, wb_valid, wb_ready, wb_ovf, err;
    logic [TAGW-1:0] issue_tag, wb_tag;
    logic [31:0] mul_y, wb_data;

    fmul_wb #(.NSTAGE(NSTAGE), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_ready(issue_ready),
        .mul_y(mul_y), .mul_ovf(mul_ovf),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_tag(wb_tag), .wb_ovf(wb_ovf), .err(err)
    );

    always #5 clk = ~clk;

    op_t         sb[$];
    int          m_cnt;
    bit          m_err;
    bit          issued_at[int];
    logic        ovf_at[int];
    logic [31:0] y_at[int];
    int          cyc, n_vec, n_bad, n_acc;
    op_t         idle_op;
    op_t         vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive, check at negedge, update model at posedge
    task automatic step(input bit iv, input op_t op, input bit wr, input bit fl, input bit rs);
        bit rdy;
        rst = rs; flush = fl; issue_valid = iv; issue_tag = op.tag; wb_ready = wr;
        mul_ovf = ovf_at.exists(cyc) ? ovf_at[cyc] : 1'($urandom);
        mul_y   = y_at.exists(cyc) ? y_at[cyc] : 32'($urandom);
        @(negedge clk);
        rdy = (sb.size() < DEPTH);
        chk("issue_ready", {31'd0, issue_ready}, {31'd0, rdy});
        chk("wb_valid", {31'd0, wb_valid}, {31'd0, m_cnt > 0});
        chk("err", {31'd0, err}, {31'd0, m_err});
        if (m_cnt > 0) begin
            chk("wb_data", wb_data, sb[0].y);
            chk("wb_tag", {26'd0, wb_tag}, {26'd0, sb[0].tag});
            chk("wb_ovf", {31'd0, wb_ovf}, {31'd0, sb[0].ovf});
        end else begin
            chk("idle_zero", {wb_data[31:8], wb_data[7:0] | {1'b0, wb_tag, wb_ovf}}, 32'd0);
        end
        @(posedge clk);
        if (rs) begin
            sb.delete(); m_cnt = 0; m_err = 1'b0; issued_at.delete();
        end else begin
            if (iv && !rdy) m_err = 1'b1;
            if (fl) begin
                sb.delete(); m_cnt = 0; issued_at.delete();
            end else begin
                if (m_cnt > 0 && wr) begin
                    void'(sb.pop_front());
                    m_cnt--;
                end
                if (issued_at.exists(cyc - NSTAGE)) m_cnt++;
                if (iv && rdy) begin
                    sb.push_back(op);
                    issued_at[cyc] = 1'b1;
                    ovf_at[cyc + NSTAGE - 1] = op.ovf;
                    y_at[cyc + NSTAGE] = op.y;
                    n_acc++;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n, input bit wr);
        for (int i = 0; i < n; i++) step(1'b0, idle_op, wr, 1'b0, 1'b0);
    endtask

    initial begin
        idle_op = '{tag: 6'd0, y: 32'd0, ovf: 1'b0};
        vecs[0] = '{tag: 6'd1,  y: 32'h3F800000, ovf: 1'b0};
        vecs[1] = '{tag: 6'd63, y: 32'hFFFFFFFF, ovf: 1'b1};
        vecs[2] = '{tag: 6'd0,  y: 32'h00000000, ovf: 1'b1};
        vecs[3] = '{tag: 6'd42, y: 32'h7F800000, ovf: 1'b1};
        vecs[4] = '{tag: 6'd21, y: 32'hC0490FDB, ovf: 1'b0};
        vecs[5] = '{tag: 6'd7,  y: 32'h00000001, ovf: 1'b0};
        vecs[6] = '{tag: 6'd32, y: 32'h80000000, ovf: 1'b1};
        vecs[7] = '{tag: 6'd9,  y: 32'hA5A5A5A5, ovf: 1'b0};
        n_vec = 0; n_bad = 0; n_acc = 0; cyc = 0; m_cnt = 0; m_err = 1'b0;
        rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_tag = '0;
        wb_ready = 1'b0; mul_y = 32'd0; mul_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single op: ovf at issue+2, y at issue+3, wb_valid at issue+4
        step(1'b1, '{tag: 6'd5, y: 32'h40400000, ovf: 1'b1}, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        chk("single_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("single_wb_data", wb_data, 32'h40400000);
        idle(2, 1'b1);

        // Table vectors with gaps and an occasional stall
        for (int i = 0; i < 8; i++) begin
            step(1'b1, vecs[i], 1'b1, 1'b0, 1'b0);
            idle(1 + (i % 3), (i % 2) == 0);
        end
        idle(6, 1'b1);

        // Streaming 20 ops, issuing as soon as credit allows
        for (int t = 0; t < 20; t++) begin
            int guard;
            guard = 0;
            while (!issue_ready && guard < 20) begin
                idle(1, 1'b1);
                guard++;
            end
            chk("stream_ready_timeout", 32'(guard < 20), 32'd1);
            step(1'b1, '{tag: 6'(t), y: 32'h1000 + 32'(t), ovf: 1'(t % 3 == 0)}, 1'b1, 1'b0, 1'b0);
        end
        idle(8, 1'b1);

        // Back-pressure: issue_valid follows issue_ready, consumer stalled
        n_acc = 0;
        for (int t = 0; t < 8; t++) begin
            step(issue_ready, '{tag: 6'(40 + t), y: 32'hB000 + 32'(t), ovf: 1'b0}, 1'b0, 1'b0, 1'b0);
        end
        chk("bp_accepted", 32'(n_acc), 32'd4);
        chk("bp_err", {31'd0, err}, 32'd0);
        idle(6, 1'b1);

        // Flush with two ops buffered and two in flight
        for (int t = 0; t < 4; t++) begin
            step(1'b1, '{tag: 6'(50 + t), y: 32'hF000 + 32'(t), ovf: 1'b1}, 1'b0, 1'b0, 1'b0);
        end
        idle(1, 1'b0);
        step(1'b1, '{tag: 6'd60, y: 32'hDEAD, ovf: 1'b0}, 1'b1, 1'b1, 1'b0);
        chk("flush_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("flush_issue_ready", {31'd0, issue_ready}, 32'd1);
        idle(6, 1'b1);

        // Over-issue while full: dropped ops, sticky err
        for (int t = 0; t < 7; t++) begin
            step(1'b1, '{tag: 6'(10 + t), y: 32'hC000 + 32'(t), ovf: 1'(t % 2)}, 1'b0, 1'b0, 1'b0);
        end
        chk("over_err", {31'd0, err}, 32'd1);
        idle(6, 1'b1);
        step(1'b1, vecs[3], 1'b1, 1'b0, 1'b0);
        idle(6, 1'b1);
        chk("over_err_held", {31'd0, err}, 32'd1);

        // Reset in the cycle the push happens
        step(1'b1, vecs[4], 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);
        step(1'b0, idle_op, 1'b1, 1'b0, 1'b1);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        idle(6, 1'b1);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
